uart_bus_master: RTL and testbench

UART-to-bus bridge: decodes command frames arriving as a byte stream from a UART receiver, issues one 32-bit register read or write per frame on the peripheral register bus as initiator, and returns a response frame to a UART transmitter byte path. Sits between a uart_rx/uart_tx pair and the SoC register interconnect, so an external host can peek and poke any peripheral, including uart_core, for bring-up and firmware download.

---
 rtl/uart_bus_master_pkg.sv | 47 ++++
 rtl/uart_bus_master_ser.sv | 88 ++++++++
 rtl/uart_bus_master.sv | 194 +++++++++++++++++++
 tb/tb_uart_bus_master.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_master_pkg.sv
// ============================================================================
// Module   : uart_bus_master_pkg
// Brief    : Frame constants, command/status codes and FSM states shared by
//            the UART bus master. Honors macro UART_BUS_MASTER_CSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_bus_master_pkg;

    localparam logic [7:0] c_sof          = 8'hA5;
    localparam logic [7:0] c_resp_hdr     = 8'h5A;

    localparam logic [7:0] c_cmd_read     = 8'h01;
    localparam logic [7:0] c_cmd_write    = 8'h02;

    localparam logic [7:0] c_status_ok    = 8'h00;
    localparam logic [7:0] c_status_csum  = 8'h01;
    localparam logic [7:0] c_status_cmd   = 8'h02;
    localparam logic [7:0] c_status_bus   = 8'h03;

`ifdef UART_BUS_MASTER_CSUM_EN
    localparam logic [2:0] c_resp_len_short = 3'd3;
    localparam logic [2:0] c_resp_len_read  = 3'd7;
`else
    localparam logic [2:0] c_resp_len_short = 3'd2;
    localparam logic [2:0] c_resp_len_read  = 3'd6;
`endif

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CMD      = 4'd1,
        S_ADDR     = 4'd2,
        S_DATA     = 4'd3,
        S_CSUM     = 4'd4,
        S_BUS_REQ  = 4'd5,
        S_BUS_WAIT = 4'd6,
        S_RESP     = 4'd7
    } state_t;

    function automatic logic [7:0] xor_bytes(input logic [31:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_bus_master_ser.sv
// ============================================================================
// Module   : uart_bus_master_ser
// Brief    : Response frame serializer (header, status, optional read data,
//            optional checksum under UART_BUS_MASTER_CSUM_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bus_master_ser
    import uart_bus_master_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [7:0]  status_i,
    input  logic [31:0] data_i,
    input  logic        data_en_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        done_o
);

    logic        r_valid;
    logic [2:0]  r_idx;
    logic [2:0]  r_last;
    logic [7:0]  r_status;
    logic [31:0] r_data;
    logic        w_hs;
    logic [7:0]  w_byte;
`ifdef UART_BUS_MASTER_CSUM_EN
    logic [7:0]  r_csum;
`endif

    assign w_hs       = r_valid & tx_ready_i;
    assign done_o     = w_hs && (r_idx == r_last);
    assign tx_valid_o = r_valid;
    assign tx_data_o  = r_valid ? w_byte : 8'h00;

    // Data bytes are consumed from the low lane; the word shifts after each one.
    always_comb begin
        w_byte = r_data[7:0];
        if (r_idx == 3'd0) begin
            w_byte = c_resp_hdr;
        end else if (r_idx == 3'd1) begin
            w_byte = r_status;
`ifdef UART_BUS_MASTER_CSUM_EN
        end else if (r_idx == r_last) begin
            w_byte = r_csum;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid  <= 1'b0;
            r_idx    <= 3'd0;
            r_last   <= 3'd0;
            r_status <= 8'h00;
            r_data   <= 32'h0;
`ifdef UART_BUS_MASTER_CSUM_EN
            r_csum   <= 8'h00;
`endif
        end else if (load_i) begin
            r_valid  <= 1'b1;
            r_idx    <= 3'd0;
            r_status <= status_i;
            r_data   <= data_i;
            r_last   <= data_en_i ? (c_resp_len_read - 3'd1) : (c_resp_len_short - 3'd1);
`ifdef UART_BUS_MASTER_CSUM_EN
            r_csum   <= status_i ^ (data_en_i ? xor_bytes(data_i) : 8'h00);
`endif
        end else if (w_hs) begin
            if (r_idx == r_last) begin
                r_valid <= 1'b0;
                r_idx   <= 3'd0;
            end else begin
                r_idx <= r_idx + 3'd1;
                if (r_idx >= 3'd2) begin
                    r_data <= r_data >> 8;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_bus_master.sv
// ============================================================================
// Module   : uart_bus_master
// Brief    : UART byte-stream to 32-bit register bus bridge. Optional frame
//            checksum enabled by macro UART_BUS_MASTER_CSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    input  logic        gnt_i,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i,
    input  logic        err_i,
    output logic        busy_o,
    output logic        overrun_o
);

    localparam int                   c_timer_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT_CYCLES - 1);
`ifdef UART_BUS_MASTER_CSUM_EN
    localparam state_t               c_after_payload = S_CSUM;
`else
    localparam state_t               c_after_payload = S_BUS_REQ;
`endif

    state_t               r_state, w_state_next;
    logic [1:0]           r_cnt;
    logic [c_timer_w-1:0] r_timer;
    logic                 r_we;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic                 r_overrun;
    logic                 w_in_frame;
    logic                 w_timeout;
    logic                 w_bus_done;
    logic                 w_ser_load;
    logic [7:0]           w_ser_status;
    logic                 w_ser_data_en;
    logic                 w_ser_done;
`ifdef UART_BUS_MASTER_CSUM_EN
    logic [7:0]           r_csum;
`endif

    assign req_o     = (r_state == S_BUS_REQ);
    assign we_o      = r_we;
    assign addr_o    = r_addr;
    assign wdata_o   = r_wdata;
    assign be_o      = 4'hF;
    assign busy_o    = (r_state != S_IDLE);
    assign overrun_o = r_overrun;

    always_comb begin
        w_state_next  = r_state;
        w_ser_load    = 1'b0;
        w_ser_status  = c_status_ok;
        w_ser_data_en = 1'b0;
        w_in_frame    = (r_state == S_CMD) || (r_state == S_ADDR) ||
                        (r_state == S_DATA) || (r_state == S_CSUM);
        w_timeout     = w_in_frame && !rx_valid_i && (r_timer >= c_timer_last);
        w_bus_done    = ((r_state == S_BUS_REQ) && gnt_i && rvalid_i) ||
                        ((r_state == S_BUS_WAIT) && rvalid_i);
        case (r_state)
            S_IDLE: begin
                if (rx_valid_i && (rx_data_i == c_sof)) w_state_next = S_CMD;
            end
            S_CMD: begin
                if (rx_valid_i) begin
                    if ((rx_data_i == c_cmd_read) || (rx_data_i == c_cmd_write)) begin
                        w_state_next = S_ADDR;
                    end else begin
                        w_state_next = S_RESP;
                        w_ser_load   = 1'b1;
                        w_ser_status = c_status_cmd;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid_i && (r_cnt == 2'd3)) w_state_next = r_we ? S_DATA : c_after_payload;
            end
            S_DATA: begin
                if (rx_valid_i && (r_cnt == 2'd3)) w_state_next = c_after_payload;
            end
`ifdef UART_BUS_MASTER_CSUM_EN
            S_CSUM: begin
                if (rx_valid_i) begin
                    if (rx_data_i == r_csum) begin
                        w_state_next = S_BUS_REQ;
                    end else begin
                        w_state_next = S_RESP;
                        w_ser_load   = 1'b1;
                        w_ser_status = c_status_csum;
                    end
                end
            end
`endif
            S_BUS_REQ: begin
                if (gnt_i) w_state_next = S_BUS_WAIT;
            end
            S_BUS_WAIT: ;
            S_RESP: begin
                if (w_ser_done) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_bus_done) begin
            w_state_next  = S_RESP;
            w_ser_load    = 1'b1;
            w_ser_status  = err_i ? c_status_bus : c_status_ok;
            w_ser_data_en = !err_i && !r_we;
        end
        if (w_timeout) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= 2'd0;
            r_timer   <= '0;
            r_we      <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_overrun <= rx_valid_i && ((r_state == S_BUS_REQ) ||
                         (r_state == S_BUS_WAIT) || (r_state == S_RESP));
            if (w_in_frame && !rx_valid_i && !w_timeout) begin
                r_timer <= r_timer + c_timer_w'(1);
            end else begin
                r_timer <= '0;
            end
            if (rx_valid_i) begin
                case (r_state)
                    S_IDLE: r_cnt <= 2'd0;
                    S_CMD:  r_we  <= (rx_data_i == c_cmd_write);
                    S_ADDR: begin
                        r_addr[{r_cnt, 3'b000} +: 8] <= rx_data_i;
                        // Word address: the two lowest bits never reach the bus.
                        if (r_cnt == 2'd0) r_addr[1:0] <= 2'b00;
                        r_cnt <= r_cnt + 2'd1;
                    end
                    S_DATA: begin
                        r_wdata[{r_cnt, 3'b000} +: 8] <= rx_data_i;
                        r_cnt <= r_cnt + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef UART_BUS_MASTER_CSUM_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_csum <= 8'h00;
        end else if (rx_valid_i) begin
            if (r_state == S_IDLE) r_csum <= 8'h00;
            else if (w_in_frame)   r_csum <= r_csum ^ rx_data_i;
        end
    end
`endif

    uart_bus_master_ser u_ser (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_ser_load),
        .status_i   (w_ser_status),
        .data_i     (rdata_i),
        .data_en_i  (w_ser_data_en),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .tx_ready_i (tx_ready_i),
        .done_o     (w_ser_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_uart_bus_master.sv
// ============================================================================
// Module   : tb_uart_bus_master
// Brief    : Directed self-checking bench for uart_bus_master; adapts expected
//            frames to UART_BUS_MASTER_CSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_bus_master;

`ifdef UART_BUS_MASTER_CSUM_EN
    localparam int c_cs = 1;
`else
    localparam int c_cs = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i = 1'b1;
    logic        req_o;
    logic        we_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic        gnt_i = 1'b0;
    logic        rvalid_i = 1'b0;
    logic [31:0] rdata_i = 32'h0;
    logic        err_i = 1'b0;
    logic        busy_o;
    logic        overrun_o;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [7:0]  rsp [0:7];
    int          cycles;

    always #5 clk = ~clk;

    uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .rx_valid_i(rx_valid_i),
        .rx_data_i (rx_data_i),
        .tx_valid_o(tx_valid_o),
        .tx_data_o (tx_data_o),
        .tx_ready_i(tx_ready_i),
        .req_o     (req_o),
        .we_o      (we_o),
        .addr_o    (addr_o),
        .wdata_o   (wdata_o),
        .be_o      (be_o),
        .gnt_i     (gnt_i),
        .rvalid_i  (rvalid_i),
        .rdata_i   (rdata_i),
        .err_i     (err_i),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        tick;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a,
                              input logic [31:0] d, input logic [7:0] cs_flip);
        logic [7:0] cs;
        cs = cmd;
        send_byte(8'hA5);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) begin
            send_byte(a[8*i +: 8]);
            cs = cs ^ a[8*i +: 8];
        end
        if (cmd == 8'h02) begin
            for (int i = 0; i < 4; i++) begin
                send_byte(d[8*i +: 8]);
                cs = cs ^ d[8*i +: 8];
            end
        end
`ifdef UART_BUS_MASTER_CSUM_EN
        send_byte(cs ^ cs_flip);
`endif
    endtask

    // Accepts n response bytes; with toggle set, tx_ready_i alternates 0/1 and
    // every stalled byte must still be presented unchanged on the next cycle.
    task automatic collect(input string tag, input int n, input bit toggle, output int cyc);
        int         got;
        logic [7:0] prev_d;
        bit         prev_stall;
        got = 0;
        cyc = 0;
        prev_d = 8'h00;
        prev_stall = 1'b0;
        while (got < n && cyc < 100) begin
            tx_ready_i = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (prev_stall) check({tag, "_hold"}, {23'h0, tx_valid_o, tx_data_o}, {23'h0, 1'b1, prev_d});
            if (tx_valid_o && tx_ready_i) begin
                rsp[got] = tx_data_o;
                got++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = tx_valid_o;
                prev_d     = tx_data_o;
            end
            tick;
            cyc++;
        end
        tx_ready_i = 1'b1;
        check({tag, "_count"}, got, n);
        check({tag, "_end_valid"}, {31'h0, tx_valid_o}, 32'h0);
        check({tag, "_end_busy"}, {31'h0, busy_o}, 32'h0);
    endtask

    task automatic check_resp(input string tag, input int n, input logic [55:0] e);
        for (int i = 0; i < n; i++) begin
            check(tag, {24'h0, rsp[i]}, {24'h0, e[55-8*i -: 8]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick;
        tick;
        rst_i = 1'b0;
        // Reset state
        check("rst_req", {31'h0, req_o}, 32'h0);
        check("rst_we", {31'h0, we_o}, 32'h0);
        check("rst_addr", addr_o, 32'h0);
        check("rst_wdata", wdata_o, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data_o}, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_overrun", {31'h0, overrun_o}, 32'h0);

        // Resync: non-SOF bytes in IDLE are ignored
        send_byte(8'h00);
        send_byte(8'h5A);
        send_byte(8'h02);
        check("resync_busy", {31'h0, busy_o}, 32'h0);

        // Write; completion two cycles after grant, ready held high
        send_frame(8'h02, 32'h2000_0010, 32'hDEAD_BEEF, 8'h00);
        check("wr_req", {31'h0, req_o}, 32'h1);
        check("wr_we", {31'h0, we_o}, 32'h1);
        check("wr_addr", addr_o, 32'h2000_0010);
        check("wr_wdata", wdata_o, 32'hDEAD_BEEF);
        check("wr_be", {28'h0, be_o}, 32'hF);
        gnt_i = 1'b1;
        tick;
        gnt_i = 1'b0;
        check("wr_req_drop", {31'h0, req_o}, 32'h0);
        check("wr_no_tx_yet", {31'h0, tx_valid_o}, 32'h0);
        tick;
        rvalid_i = 1'b1;
        tick;
        rvalid_i = 1'b0;
        check("wr_hdr_first", {23'h0, tx_valid_o, tx_data_o}, {23'h0, 1'b1, 8'h5A});
        collect("wr_rsp", 2 + c_cs, 1'b0, cycles);
        check("wr_no_bubbles", cycles, 2 + c_cs);
        check_resp("wr_rsp", 2 + c_cs, 56'h5A_00_00_00_00_00_00);

        // Read with overrun byte in BUS_WAIT, rvalid 3 cycles after gnt
        send_frame(8'h01, 32'h3000_0007, 32'h0, 8'h00);
        check("rd_req", {31'h0, req_o}, 32'h1);
        check("rd_we", {31'h0, we_o}, 32'h0);
        check("rd_addr_aligned", addr_o, 32'h3000_0004);
        gnt_i = 1'b1;
        tick;
        gnt_i = 1'b0;
        rx_valid_i = 1'b1;
        rx_data_i  = 8'hA5;
        tick;
        rx_valid_i = 1'b0;
        check("ovr_pulse", {31'h0, overrun_o}, 32'h1);
        check("ovr_busy", {31'h0, busy_o}, 32'h1);
        tick;
        check("ovr_single", {31'h0, overrun_o}, 32'h0);
        rvalid_i = 1'b1;
        rdata_i  = 32'h1234_5678;
        tick;
        rvalid_i = 1'b0;
        rdata_i  = 32'h0;
        check("rd_hdr_first", {23'h0, tx_valid_o, tx_data_o}, {23'h0, 1'b1, 8'h5A});
        collect("rd_rsp", 6 + c_cs, 1'b1, cycles);
        check_resp("rd_rsp", 6 + c_cs, 56'h5A_00_78_56_34_12_08);

        // Unknown command answers immediately, no bus access
        send_byte(8'hA5);
        send_byte(8'h07);
        check("cmd_no_req", {31'h0, req_o}, 32'h0);
        check("cmd_hdr_first", {23'h0, tx_valid_o, tx_data_o}, {23'h0, 1'b1, 8'h5A});
        collect("cmd_rsp", 2 + c_cs, 1'b0, cycles);
        check_resp("cmd_rsp", 2 + c_cs, 56'h5A_02_02_00_00_00_00);

`ifdef UART_BUS_MASTER_CSUM_EN
        // Corrupted checksum: status 0x01, no bus request
        send_frame(8'h02, 32'h2000_0010, 32'hDEAD_BEEF, 8'hFF);
        check("cs_no_req", {31'h0, req_o}, 32'h0);
        check("cs_hdr_first", {23'h0, tx_valid_o, tx_data_o}, {23'h0, 1'b1, 8'h5A});
        collect("cs_rsp", 3, 1'b0, cycles);
        check_resp("cs_rsp", 3, 56'h5A_01_01_00_00_00_00);
`endif

        // Bus error with gnt and rvalid in the same cycle
        send_frame(8'h01, 32'h4000_0008, 32'h0, 8'h00);
        check("err_req", {31'h0, req_o}, 32'h1);
        gnt_i    = 1'b1;
        rvalid_i = 1'b1;
        err_i    = 1'b1;
        rdata_i  = 32'hFFFF_FFFF;
        tick;
        gnt_i    = 1'b0;
        rvalid_i = 1'b0;
        err_i    = 1'b0;
        rdata_i  = 32'h0;
        check("err_req_drop", {31'h0, req_o}, 32'h0);
        check("err_hdr_first", {23'h0, tx_valid_o, tx_data_o}, {23'h0, 1'b1, 8'h5A});
        collect("err_rsp", 2 + c_cs, 1'b0, cycles);
        check_resp("err_rsp", 2 + c_cs, 56'h5A_03_03_00_00_00_00);

        // Inter-byte timeout after two address bytes (TIMEOUT_CYCLES = 16)
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (15) tick;
        check("to_still_busy", {31'h0, busy_o}, 32'h1);
        tick;
        check("to_idle", {31'h0, busy_o}, 32'h0);
        repeat (4) tick;
        check("to_no_tx", {31'h0, tx_valid_o}, 32'h0);
        check("to_no_req", {31'h0, req_o}, 32'h0);

        // Next frame after timeout handled normally
        send_frame(8'h02, 32'h0000_0100, 32'hCAFE_F00D, 8'h00);
        check("to2_req", {31'h0, req_o}, 32'h1);
        check("to2_addr", addr_o, 32'h0000_0100);
        check("to2_wdata", wdata_o, 32'hCAFE_F00D);
        gnt_i    = 1'b1;
        rvalid_i = 1'b1;
        tick;
        gnt_i    = 1'b0;
        rvalid_i = 1'b0;
        collect("to2_rsp", 2 + c_cs, 1'b0, cycles);
        check_resp("to2_rsp", 2 + c_cs, 56'h5A_00_00_00_00_00_00);

        // Reset during an outstanding request abandons it
        send_frame(8'h01, 32'h5000_0000, 32'h0, 8'h00);
        check("mrst_req", {31'h0, req_o}, 32'h1);
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        check("mrst_req_drop", {31'h0, req_o}, 32'h0);
        check("mrst_busy", {31'h0, busy_o}, 32'h0);
        check("mrst_tx", {31'h0, tx_valid_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
